csb_cfgrom_req_gate: RTL and testbench

Upstream stage of the cfgrom slave on the CSB ring. It accepts CSB requests from the CSB master, decodes the address window, and forwards in-window requests to the cfgrom through a registered 2-entry skid buffer. Out-of-window requests are answered locally with an error response. It tracks outstanding non-posted requests so that cfgrom responses and local responses reach the master in request order.

---
 rtl/csb_cfgrom_req_gate.sv | 123 ++++++++++++
 tb/tb_csb_cfgrom_req_gate.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csb_cfgrom_req_gate.sv
// CSB request front end for the cfgrom slave: in-window requests go to the cfgrom
// through a 2-entry skid buffer, out-of-window requests get a local error response.
module csb_cfgrom_req_gate #(
  parameter logic [21:0] BASE_ADDR       = 22'h000000,
  parameter int          SPAN_LOG2       = 10,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        csb_req_pvld,
  output logic        csb_req_prdy,
  input  logic [62:0] csb_req_pd,
  output logic        csb2cfgrom_req_pvld,
  input  logic        csb2cfgrom_req_prdy,
  output logic [62:0] csb2cfgrom_req_pd,
  input  logic        cfgrom2csb_resp_valid,
  input  logic [33:0] cfgrom2csb_resp_pd,
  output logic        csb_resp_valid,
  output logic [33:0] csb_resp_pd,
  output logic [15:0] oob_err_cnt,
  output logic        proto_err
);

  localparam logic [3:0] LP_MAX_OUT = 4'(MAX_OUTSTANDING);

  logic [62:0] r_mem [2];
  logic        r_wrPtr;
  logic        r_rdPtr;
  logic [1:0]  r_count;
  logic        r_notFull;
  logic [3:0]  r_outstanding;
  logic        r_respValid;
  logic [33:0] r_respPd;
  logic [15:0] r_oobCnt;
  logic        r_protoErr;

  logic [62:0] w_head;
  logic        w_hasHead;
  logic        w_headWrite;
  logic        w_needResp;
  logic        w_inWindow;
  logic        w_push;
  logic        w_fwdValid;
  logic        w_fwdPop;
  logic        w_localPop;
  logic        w_pop;
  logic        w_outInc;
  logic        w_outDec;
  logic        w_localResp;
  logic [1:0]  w_countNext;

  assign w_head      = r_mem[r_rdPtr];
  assign w_hasHead   = (r_count != 2'd0);
  assign w_headWrite = w_head[54];
  assign w_needResp  = ~w_headWrite | w_head[55];
  assign w_inWindow  = (w_head[21:SPAN_LOG2] == BASE_ADDR[21:SPAN_LOG2]);

  // Ready comes from a register; reset forces it low while asserted.
  assign csb_req_prdy = r_notFull & ~nvdla_core_rst;
  assign w_push       = csb_req_pvld & csb_req_prdy;

  // Posted in-window writes never need a response slot, so they bypass the limit.
  assign w_fwdValid  = w_hasHead & w_inWindow & ((r_outstanding < LP_MAX_OUT) | ~w_needResp);
  assign w_fwdPop    = w_fwdValid & csb2cfgrom_req_prdy;
  assign w_localPop  = w_hasHead & ~w_inWindow & (r_outstanding == 4'd0) & ~cfgrom2csb_resp_valid;
  assign w_pop       = w_fwdPop | w_localPop;
  assign w_localResp = w_localPop & w_needResp;
  assign w_countNext = r_count + {1'b0, w_push} - {1'b0, w_pop};

  assign w_outInc = w_fwdPop & w_needResp;
  assign w_outDec = cfgrom2csb_resp_valid & (r_outstanding != 4'd0);

  always_ff @(posedge nvdla_core_clk) begin
    if (w_push) r_mem[r_wrPtr] <= csb_req_pd;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_wrPtr   <= 1'b0;
      r_rdPtr   <= 1'b0;
      r_count   <= 2'd0;
      r_notFull <= 1'b1;
    end else begin
      if (w_push) r_wrPtr <= ~r_wrPtr;
      if (w_pop) r_rdPtr <= ~r_rdPtr;
      r_count   <= w_countNext;
      r_notFull <= (w_countNext != 2'd2);
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_outstanding <= 4'd0;
      r_protoErr    <= 1'b0;
      r_oobCnt      <= 16'd0;
    end else begin
      if (w_outInc && !w_outDec) r_outstanding <= r_outstanding + 4'd1;
      else if (!w_outInc && w_outDec) r_outstanding <= r_outstanding - 4'd1;
      if (cfgrom2csb_resp_valid && (r_outstanding == 4'd0)) r_protoErr <= 1'b1;
      if (w_localPop && (r_oobCnt != 16'hFFFF)) r_oobCnt <= r_oobCnt + 16'd1;
    end
  end

  // A local pop only happens in a cycle without a cfgrom response, so the two never collide.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_respValid <= 1'b0;
      r_respPd    <= 34'd0;
    end else begin
      r_respValid <= cfgrom2csb_resp_valid | w_localResp;
      if (cfgrom2csb_resp_valid) r_respPd <= cfgrom2csb_resp_pd;
      else if (w_localResp) r_respPd <= {w_headWrite, 1'b1, 32'h0};
    end
  end

  assign csb2cfgrom_req_pvld = w_fwdValid;
  assign csb2cfgrom_req_pd   = w_head;
  assign csb_resp_valid      = r_respValid;
  assign csb_resp_pd         = r_respPd;
  assign oob_err_cnt         = r_oobCnt;
  assign proto_err           = r_protoErr;

endmodule

// File: tb/tb_csb_cfgrom_req_gate.sv
// Self-checking bench for csb_cfgrom_req_gate: directed vector table, hand-written
// stall/reset sequences and a scoreboarded mixed-traffic run.
module tb_csb_cfgrom_req_gate;

  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csb_req_pvld = 1'b0;
  logic        csb_req_prdy;
  logic [62:0] csb_req_pd = '0;
  logic        csb2cfgrom_req_pvld;
  logic        csb2cfgrom_req_prdy = 1'b0;
  logic [62:0] csb2cfgrom_req_pd;
  logic        cfgrom2csb_resp_valid = 1'b0;
  logic [33:0] cfgrom2csb_resp_pd = '0;
  logic        csb_resp_valid;
  logic [33:0] csb_resp_pd;
  logic [15:0] oob_err_cnt;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pvld;
    logic [62:0] pd;
    logic        respVld;
    logic [33:0] respPd;
    logic        expPrdy;
    logic        expFwdVld;
    logic [62:0] expFwdPd;
    logic        expRespVld;
    logic [33:0] expRespPd;
    logic [15:0] expOob;
    logic        expProto;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  csb_cfgrom_req_gate #(
    .BASE_ADDR(22'h000000),
    .SPAN_LOG2(10),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .csb_req_pvld(csb_req_pvld),
    .csb_req_prdy(csb_req_prdy),
    .csb_req_pd(csb_req_pd),
    .csb2cfgrom_req_pvld(csb2cfgrom_req_pvld),
    .csb2cfgrom_req_prdy(csb2cfgrom_req_prdy),
    .csb2cfgrom_req_pd(csb2cfgrom_req_pd),
    .cfgrom2csb_resp_valid(cfgrom2csb_resp_valid),
    .cfgrom2csb_resp_pd(cfgrom2csb_resp_pd),
    .csb_resp_valid(csb_resp_valid),
    .csb_resp_pd(csb_resp_pd),
    .oob_err_cnt(oob_err_cnt),
    .proto_err(proto_err)
  );

  function automatic logic [62:0] mkReq(input logic [21:0] addr, input logic wr, input logic np);
    logic [31:0] wdat;
    wdat = 32'hD000_0000 | {10'd0, addr};
    return {5'd0, 1'b0, 1'b0, np, wr, wdat, addr};
  endfunction

  // What the bench's cfgrom model answers for a forwarded request.
  function automatic logic [33:0] cfgData(input logic [62:0] pd);
    return {pd[54], 1'b0, 32'h5A00_0000 ^ {10'd0, pd[21:0]}};
  endfunction

  function automatic logic needsResp(input logic [62:0] pd);
    return ~pd[54] | pd[55];
  endfunction

  function automatic logic inWin(input logic [62:0] pd);
    return (pd[21:10] == 12'd0);
  endfunction

  function automatic logic [62:0] mkRandReq();
    logic [21:0] addr;
    if ($urandom_range(0, 3) != 0) addr = 22'($urandom_range(0, 1023));
    else addr = 22'(32'h400 + $urandom_range(0, 4000));
    return mkReq(addr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  function automatic vec_t mkVec(input logic pvld, input logic [62:0] pd, input logic respVld,
                                 input logic [33:0] respPd, input logic expPrdy, input logic expFwdVld,
                                 input logic [62:0] expFwdPd, input logic expRespVld,
                                 input logic [33:0] expRespPd, input logic [15:0] expOob,
                                 input logic expProto);
    vec_t v;
    v.pvld = pvld; v.pd = pd; v.respVld = respVld; v.respPd = respPd;
    v.expPrdy = expPrdy; v.expFwdVld = expFwdVld; v.expFwdPd = expFwdPd;
    v.expRespVld = expRespVld; v.expRespPd = expRespPd; v.expOob = expOob; v.expProto = expProto;
    return v;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    csb_req_pvld          = v.pvld;
    csb_req_pd            = v.pd;
    csb2cfgrom_req_prdy   = 1'b1;
    cfgrom2csb_resp_valid = v.respVld;
    cfgrom2csb_resp_pd    = v.respPd;
  endtask

  initial begin
    logic [62:0] z;
    logic [62:0] curPd;
    logic [62:0] fwdExp[$];
    logic [33:0] respExp[$];
    logic [33:0] pend[$];
    int nReq;
    int nFwd;
    int modelOut;
    int accepted;
    int oobExp;
    z = '0;

    // Rows: pvld, pd, respVld, respPd | prdy, fwdVld, fwdPd, respVld, respPd, oob, proto
    vecs.push_back(mkVec(1, mkReq(22'h000,0,0), 0, 34'h0, 1, 0, z, 0, 34'h0, 16'd0, 0));
    vecs.push_back(mkVec(1, mkReq(22'h001,0,0), 0, 34'h0, 1, 1, mkReq(22'h000,0,0), 0, 34'h0, 16'd0, 0));
    vecs.push_back(mkVec(1, mkReq(22'h002,0,0), 0, 34'h0, 1, 1, mkReq(22'h001,0,0), 0, 34'h0, 16'd0, 0));
    vecs.push_back(mkVec(0, z, 1, 34'h0_1234_5678, 1, 1, mkReq(22'h002,0,0), 0, 34'h0, 16'd0, 0));
    vecs.push_back(mkVec(0, z, 1, 34'h0_0000_00AB, 1, 0, z, 1, 34'h0_1234_5678, 16'd0, 0));
    vecs.push_back(mkVec(0, z, 1, 34'h2_CAFE_0001, 1, 0, z, 1, 34'h0_0000_00AB, 16'd0, 0));
    vecs.push_back(mkVec(0, z, 0, 34'h0, 1, 0, z, 1, 34'h2_CAFE_0001, 16'd0, 0));
    vecs.push_back(mkVec(0, z, 0, 34'h0, 1, 0, z, 0, 34'h0, 16'd0, 0));
    // Out-of-window read behind two outstanding reads.
    vecs.push_back(mkVec(1, mkReq(22'h010,0,0), 0, 34'h0, 1, 0, z, 0, 34'h0, 16'd0, 0));
    vecs.push_back(mkVec(1, mkReq(22'h011,0,0), 0, 34'h0, 1, 1, mkReq(22'h010,0,0), 0, 34'h0, 16'd0, 0));
    vecs.push_back(mkVec(1, mkReq(22'h400,0,0), 0, 34'h0, 1, 1, mkReq(22'h011,0,0), 0, 34'h0, 16'd0, 0));
    vecs.push_back(mkVec(0, z, 0, 34'h0, 1, 0, z, 0, 34'h0, 16'd0, 0));
    vecs.push_back(mkVec(0, z, 1, 34'h0_0000_0111, 1, 0, z, 0, 34'h0, 16'd0, 0));
    vecs.push_back(mkVec(0, z, 0, 34'h0, 1, 0, z, 1, 34'h0_0000_0111, 16'd0, 0));
    vecs.push_back(mkVec(0, z, 1, 34'h0_0000_0222, 1, 0, z, 0, 34'h0, 16'd0, 0));
    vecs.push_back(mkVec(0, z, 0, 34'h0, 1, 0, z, 1, 34'h0_0000_0222, 16'd0, 0));
    vecs.push_back(mkVec(0, z, 0, 34'h0, 1, 0, z, 1, 34'h1_0000_0000, 16'd1, 0));
    vecs.push_back(mkVec(0, z, 0, 34'h0, 1, 0, z, 0, 34'h0, 16'd1, 0));
    // Posted then non-posted out-of-window writes.
    vecs.push_back(mkVec(1, mkReq(22'h400,1,0), 0, 34'h0, 1, 0, z, 0, 34'h0, 16'd1, 0));
    vecs.push_back(mkVec(1, mkReq(22'h400,1,1), 0, 34'h0, 1, 0, z, 0, 34'h0, 16'd1, 0));
    vecs.push_back(mkVec(0, z, 0, 34'h0, 1, 0, z, 0, 34'h0, 16'd2, 0));
    vecs.push_back(mkVec(0, z, 0, 34'h0, 1, 0, z, 1, 34'h3_0000_0000, 16'd3, 0));
    vecs.push_back(mkVec(0, z, 0, 34'h0, 1, 0, z, 0, 34'h0, 16'd3, 0));
    // Stray cfgrom response, then the last in-window address.
    vecs.push_back(mkVec(0, z, 1, 34'h0_0000_0055, 1, 0, z, 0, 34'h0, 16'd3, 0));
    vecs.push_back(mkVec(0, z, 0, 34'h0, 1, 0, z, 1, 34'h0_0000_0055, 16'd3, 1));
    vecs.push_back(mkVec(1, mkReq(22'h3FF,1,0), 0, 34'h0, 1, 0, z, 0, 34'h0, 16'd3, 1));
    vecs.push_back(mkVec(1, mkReq(22'h3FF,0,0), 0, 34'h0, 1, 1, mkReq(22'h3FF,1,0), 0, 34'h0, 16'd3, 1));
    vecs.push_back(mkVec(0, z, 0, 34'h0, 1, 1, mkReq(22'h3FF,0,0), 0, 34'h0, 16'd3, 1));
    vecs.push_back(mkVec(0, z, 1, 34'h0_0000_03FF, 1, 0, z, 0, 34'h0, 16'd3, 1));
    vecs.push_back(mkVec(0, z, 0, 34'h0, 1, 0, z, 1, 34'h0_0000_03FF, 16'd3, 1));

    // Reset state.
    repeat (2) nextCycle();
    checkOutput("rst prdy", 64'(csb_req_prdy), 64'd0);
    checkOutput("rst fwdVld", 64'(csb2cfgrom_req_pvld), 64'd0);
    checkOutput("rst respVld", 64'(csb_resp_valid), 64'd0);
    checkOutput("rst respPd", 64'(csb_resp_pd), 64'd0);
    checkOutput("rst oob", 64'(oob_err_cnt), 64'd0);
    checkOutput("rst proto", 64'(proto_err), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d prdy", i), 64'(csb_req_prdy), 64'(vecs[i].expPrdy));
      checkOutput($sformatf("v%0d fwdVld", i), 64'(csb2cfgrom_req_pvld), 64'(vecs[i].expFwdVld));
      if (vecs[i].expFwdVld)
        checkOutput($sformatf("v%0d fwdPd", i), 64'(csb2cfgrom_req_pd), 64'(vecs[i].expFwdPd));
      checkOutput($sformatf("v%0d respVld", i), 64'(csb_resp_valid), 64'(vecs[i].expRespVld));
      if (vecs[i].expRespVld)
        checkOutput($sformatf("v%0d respPd", i), 64'(csb_resp_pd), 64'(vecs[i].expRespPd));
      checkOutput($sformatf("v%0d oob", i), 64'(oob_err_cnt), 64'(vecs[i].expOob));
      checkOutput($sformatf("v%0d proto", i), 64'(proto_err), 64'(vecs[i].expProto));
      nextCycle();
    end

    // Reset with two requests parked in the buffer.
    cfgrom2csb_resp_valid = 1'b0;
    csb2cfgrom_req_prdy = 1'b0;
    csb_req_pvld = 1'b1;
    csb_req_pd = mkReq(22'h030, 0, 0);
    #1; checkOutput("park0 prdy", 64'(csb_req_prdy), 64'd1);
    nextCycle();
    csb_req_pd = mkReq(22'h031, 0, 0);
    #1; checkOutput("park1 prdy", 64'(csb_req_prdy), 64'd1);
    nextCycle();
    csb_req_pvld = 1'b0;
    #1;
    checkOutput("park full prdy", 64'(csb_req_prdy), 64'd0);
    checkOutput("park fwdVld", 64'(csb2cfgrom_req_pvld), 64'd1);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("post-rst prdy", 64'(csb_req_prdy), 64'd1);
    checkOutput("post-rst fwdVld", 64'(csb2cfgrom_req_pvld), 64'd0);
    checkOutput("post-rst respVld", 64'(csb_resp_valid), 64'd0);
    checkOutput("post-rst oob", 64'(oob_err_cnt), 64'd0);
    checkOutput("post-rst proto", 64'(proto_err), 64'd0);
    csb2cfgrom_req_prdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      nextCycle();
      checkOutput($sformatf("post-rst idle%0d fwdVld", c), 64'(csb2cfgrom_req_pvld), 64'd0);
    end
    nextCycle();

    // Six reads with no responses: the outstanding limit stalls the fifth.
    nReq = 0;
    nFwd = 0;
    for (int c = 0; c < 12; c++) begin
      csb2cfgrom_req_prdy = 1'b1;
      cfgrom2csb_resp_valid = 1'b0;
      csb_req_pvld = (nReq < 6);
      csb_req_pd = mkReq(22'(32 + nReq), 0, 0);
      #1;
      if (csb2cfgrom_req_pvld && csb2cfgrom_req_prdy) nFwd++;
      if (csb_req_pvld && csb_req_prdy) nReq++;
      nextCycle();
    end
    checkOutput("stall accepted", 64'(nReq), 64'd6);
    checkOutput("stall fwd count", 64'(nFwd), 64'd4);
    csb_req_pvld = 1'b0;
    #1;
    checkOutput("stall full prdy", 64'(csb_req_prdy), 64'd0);
    checkOutput("stall fwdVld", 64'(csb2cfgrom_req_pvld), 64'd0);
    cfgrom2csb_resp_valid = 1'b1;
    cfgrom2csb_resp_pd = 34'h0_0000_0020;
    #1;
    checkOutput("stall resp-cycle fwdVld", 64'(csb2cfgrom_req_pvld), 64'd0);
    nextCycle();
    cfgrom2csb_resp_valid = 1'b0;
    #1;
    checkOutput("release fwdVld", 64'(csb2cfgrom_req_pvld), 64'd1);
    checkOutput("release fwdPd", 64'(csb2cfgrom_req_pd), 64'(mkReq(22'h024, 0, 0)));
    if (csb2cfgrom_req_pvld) nFwd++;
    nextCycle();
    checkOutput("release prdy", 64'(csb_req_prdy), 64'd1);
    checkOutput("release relimit", 64'(csb2cfgrom_req_pvld), 64'd0);
    for (int c = 0; c < 8; c++) begin
      cfgrom2csb_resp_valid = (c < 5);
      cfgrom2csb_resp_pd = 34'(32'h21 + c);
      #1;
      if (csb2cfgrom_req_pvld && csb2cfgrom_req_prdy) nFwd++;
      nextCycle();
    end
    cfgrom2csb_resp_valid = 1'b0;
    checkOutput("stall total fwd", 64'(nFwd), 64'd6);

    // Mixed traffic against a scoreboard with a randomly stalling cfgrom model.
    accepted = 0;
    modelOut = 0;
    oobExp = 0;
    curPd = mkRandReq();
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (accepted == 200 && fwdExp.size() == 0 && respExp.size() == 0) break;
      csb_req_pvld = (accepted < 200) && ($urandom_range(0, 3) != 0);
      csb_req_pd = curPd;
      csb2cfgrom_req_prdy = ($urandom_range(0, 2) != 0);
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        cfgrom2csb_resp_valid = 1'b1;
        cfgrom2csb_resp_pd = pend.pop_front();
        modelOut--;
      end else begin
        cfgrom2csb_resp_valid = 1'b0;
      end
      #1;
      if (csb_resp_valid) begin
        if (respExp.size() == 0) checkOutput("rand spurious resp", 64'(csb_resp_pd), 64'h1_0000_0000_0000);
        else checkOutput("rand resp order", 64'(csb_resp_pd), 64'(respExp.pop_front()));
      end
      if (csb2cfgrom_req_pvld && csb2cfgrom_req_prdy) begin
        if (fwdExp.size() == 0) checkOutput("rand spurious fwd", 64'(csb2cfgrom_req_pd), 64'h8000_0000_0000_0000);
        else checkOutput("rand fwd order", 64'(csb2cfgrom_req_pd), 64'(fwdExp.pop_front()));
        if (needsResp(csb2cfgrom_req_pd)) begin
          pend.push_back(cfgData(csb2cfgrom_req_pd));
          modelOut++;
        end
        checkOutput("rand outstanding<=max", 64'(modelOut <= MAX_OUT), 64'd1);
      end
      if (csb_req_pvld && csb_req_prdy) begin
        accepted++;
        if (inWin(curPd)) begin
          fwdExp.push_back(curPd);
          if (needsResp(curPd)) respExp.push_back(cfgData(curPd));
        end else begin
          oobExp++;
          if (needsResp(curPd)) respExp.push_back({curPd[54], 1'b1, 32'h0});
        end
        curPd = mkRandReq();
      end
      nextCycle();
    end
    csb_req_pvld = 1'b0;
    cfgrom2csb_resp_valid = 1'b0;
    checkOutput("rand drained", 64'(accepted == 200 && fwdExp.size() == 0 && respExp.size() == 0), 64'd1);
    repeat (4) nextCycle();
    checkOutput("rand oob count", 64'(oob_err_cnt), 64'(oobExp));
    checkOutput("rand proto", 64'(proto_err), 64'd0);
    checkOutput("rand idle respVld", 64'(csb_resp_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
